// File: rtl/rr_arbiter_wlock_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter_wlock_if : request/grant bundle for rr_arbiter_wlock     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface rr_arbiter_wlock_if #(
  parameter int N_OF_INPUTS = 4
);
  localparam int IDX_W = (N_OF_INPUTS > 1) ? $clog2(N_OF_INPUTS) : 1;

  logic [N_OF_INPUTS-1:0] req_i;
  logic                   update_i;
  logic                   last_i;
  logic [N_OF_INPUTS-1:0] grant_o;
  logic [IDX_W-1:0]       grant_idx_o;
  logic                   locked_o;

  modport master (
    output req_i, update_i, last_i,
    input  grant_o, grant_idx_o, locked_o
  );

  modport slave (
    input  req_i, update_i, last_i,
    output grant_o, grant_idx_o, locked_o
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_wlock.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter_wlock : round-robin arbiter with wormhole packet lock    |
// |                    and per-winner packet quantum                   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_arbiter_wlock #(
  parameter int N_OF_INPUTS = 4,
  parameter int QUANTUM     = 1,
  parameter int LOCK_EN     = 1
) (
  input  logic                 clk,
  input  logic                 arst,
  rr_arbiter_wlock_if.slave    bus
);
  localparam int c_IDX_W = (N_OF_INPUTS > 1) ? $clog2(N_OF_INPUTS) : 1;
  localparam int c_CNT_W = $clog2(QUANTUM + 1);

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [N_OF_INPUTS-1:0] r_mask, w_mask_nxt;
  logic [c_IDX_W-1:0]     r_lock_idx, w_lock_idx_nxt;
  logic [c_CNT_W-1:0]     r_pkt_cnt, w_pkt_cnt_nxt;

  logic [N_OF_INPUTS-1:0] w_mreq, w_sel, w_grant;
  logic [c_IDX_W-1:0]     w_arb_idx, w_gnt_idx;
  logic                   w_arb_vld, w_gnt_vld, w_locked, w_fire, w_tail;

  // Masked requests take precedence; an empty masked set falls back to raw req.
  always_comb begin
    w_mreq    = bus.req_i & r_mask;
    w_sel     = (|w_mreq) ? w_mreq : bus.req_i;
    w_arb_idx = '0;
    w_arb_vld = 1'b0;
    for (int i = N_OF_INPUTS - 1; i >= 0; i--) begin
      if (w_sel[i]) begin
        w_arb_idx = c_IDX_W'(i);
        w_arb_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_locked  = (r_state == ST_LOCKED);
    w_gnt_vld = w_locked | w_arb_vld;
    w_gnt_idx = w_locked ? r_lock_idx : w_arb_idx;
    w_grant   = '0;
    for (int i = 0; i < N_OF_INPUTS; i++) begin
      w_grant[i] = w_gnt_vld && (int'(w_gnt_idx) == i);
    end
  end

  assign bus.grant_o     = w_grant;
  assign bus.grant_idx_o = w_gnt_idx;
  assign bus.locked_o    = w_locked;

  // Next state: only a transfer on a live grant can move anything.
  always_comb begin
    w_state_nxt    = r_state;
    w_mask_nxt     = r_mask;
    w_lock_idx_nxt = r_lock_idx;
    w_pkt_cnt_nxt  = r_pkt_cnt;
    w_fire         = bus.update_i & w_gnt_vld;
    w_tail         = bus.last_i | (LOCK_EN == 0);
    if (w_fire) begin
      if (!w_tail) begin
        if (r_state == ST_ARB) begin
          w_state_nxt    = ST_LOCKED;
          w_lock_idx_nxt = w_gnt_idx;
        end
      end else begin
        w_state_nxt = ST_ARB;
        if (int'(r_pkt_cnt) + 1 < QUANTUM) begin
          w_pkt_cnt_nxt = r_pkt_cnt + 1'b1;
          for (int j = 0; j < N_OF_INPUTS; j++) begin
            w_mask_nxt[j] = (j >= int'(w_gnt_idx));
          end
        end else begin
          w_pkt_cnt_nxt = '0;
          for (int j = 0; j < N_OF_INPUTS; j++) begin
            w_mask_nxt[j] = (j > int'(w_gnt_idx));
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state    <= ST_ARB;
      r_mask     <= '1;
      r_lock_idx <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mask     <= w_mask_nxt;
      r_lock_idx <= w_lock_idx_nxt;
      r_pkt_cnt  <= w_pkt_cnt_nxt;
    end
  end

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (arst) $onehot0(bus.grant_o));

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_wlock.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rr_arbiter_wlock : scoreboard bench for rr_arbiter_wlock         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_rr_arbiter_wlock;
  logic clk;
  logic arst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut 0: N=4 Q=1, dut 1: N=4 Q=2, dut 2: N=3 LOCK_EN=0, dut 3: N=1
  rr_arbiter_wlock_if #(.N_OF_INPUTS(4)) ifa ();
  rr_arbiter_wlock_if #(.N_OF_INPUTS(4)) ifb ();
  rr_arbiter_wlock_if #(.N_OF_INPUTS(3)) ifc ();
  rr_arbiter_wlock_if #(.N_OF_INPUTS(1)) ifd ();

  rr_arbiter_wlock #(.N_OF_INPUTS(4), .QUANTUM(1), .LOCK_EN(1)) u_a (.clk(clk), .arst(arst), .bus(ifa));
  rr_arbiter_wlock #(.N_OF_INPUTS(4), .QUANTUM(2), .LOCK_EN(1)) u_b (.clk(clk), .arst(arst), .bus(ifb));
  rr_arbiter_wlock #(.N_OF_INPUTS(3), .QUANTUM(1), .LOCK_EN(0)) u_c (.clk(clk), .arst(arst), .bus(ifc));
  rr_arbiter_wlock #(.N_OF_INPUTS(1), .QUANTUM(1), .LOCK_EN(1)) u_d (.clk(clk), .arst(arst), .bus(ifd));

  typedef struct {
    int         dut;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       locked;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic step(input bit rst_v, input int dut, input logic [3:0] req,
                      input logic upd, input logic lst, input bit chk,
                      input logic [3:0] eg, input logic [1:0] ei, input logic el,
                      input int tag);
    exp_t e;
    @(posedge clk);
    #1;
    arst         = rst_v;
    ifa.req_i    = (dut == 0) ? req : 4'b0;
    ifa.update_i = (dut == 0) ? upd : 1'b0;
    ifa.last_i   = (dut == 0) ? lst : 1'b0;
    ifb.req_i    = (dut == 1) ? req : 4'b0;
    ifb.update_i = (dut == 1) ? upd : 1'b0;
    ifb.last_i   = (dut == 1) ? lst : 1'b0;
    ifc.req_i    = (dut == 2) ? req[2:0] : 3'b0;
    ifc.update_i = (dut == 2) ? upd : 1'b0;
    ifc.last_i   = (dut == 2) ? lst : 1'b0;
    ifd.req_i    = (dut == 3) ? req[0] : 1'b0;
    ifd.update_i = (dut == 3) ? upd : 1'b0;
    ifd.last_i   = (dut == 3) ? lst : 1'b0;
    if (chk) begin
      e.dut = dut; e.grant = eg; e.idx = ei; e.locked = el; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    step(1'b1, -1, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 2'd0, 1'b0, 0);
  endtask

  task automatic chk(input int dut, input logic [3:0] req, input logic upd, input logic lst,
                     input logic [3:0] eg, input logic [1:0] ei, input logic el, input int tag);
    step(1'b0, dut, req, upd, lst, 1'b1, eg, ei, el, tag);
  endtask

  // Monitor: compares the oldest expectation against the DUT it names.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] ag;
    logic [1:0] ai;
    logic       al;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0:       begin ag = ifa.grant_o;          ai = ifa.grant_idx_o;         al = ifa.locked_o; end
        1:       begin ag = ifb.grant_o;          ai = ifb.grant_idx_o;         al = ifb.locked_o; end
        2:       begin ag = {1'b0, ifc.grant_o};  ai = ifc.grant_idx_o;         al = ifc.locked_o; end
        default: begin ag = {3'b0, ifd.grant_o};  ai = {1'b0, ifd.grant_idx_o}; al = ifd.locked_o; end
      endcase
      n_cmp++;
      if (ag !== e.grant || ai !== e.idx || al !== e.locked) begin
        n_err++;
        $display("FAIL t%0d dut%0d: got grant=%b idx=%0d locked=%b, want grant=%b idx=%0d locked=%b",
                 e.tag, e.dut, ag, ai, al, e.grant, e.idx, e.locked);
      end
    end
  end

  initial begin
    arst = 1'b1;
    ifa.req_i = '0; ifa.update_i = 1'b0; ifa.last_i = 1'b0;
    ifb.req_i = '0; ifb.update_i = 1'b0; ifb.last_i = 1'b0;
    ifc.req_i = '0; ifc.update_i = 1'b0; ifc.last_i = 1'b0;
    ifd.req_i = '0; ifd.update_i = 1'b0; ifd.last_i = 1'b0;

    // reset state
    do_reset();
    chk(0, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);
    chk(3, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);

    // t1: per-packet rotation, N=4 Q=1
    chk(0, 4'b1111, 1, 1, 4'b0001, 2'd0, 0, 1);
    chk(0, 4'b1111, 1, 1, 4'b0010, 2'd1, 0, 1);
    chk(0, 4'b1111, 1, 1, 4'b0100, 2'd2, 0, 1);
    chk(0, 4'b1111, 1, 1, 4'b1000, 2'd3, 0, 1);
    chk(0, 4'b1111, 1, 1, 4'b0001, 2'd0, 0, 1);

    // t5: empty mask, ignored updates with no grant, then raw-path win
    chk(0, 4'b1000, 1, 1, 4'b1000, 2'd3, 0, 5);
    chk(0, 4'b0000, 1, 0, 4'b0000, 2'd0, 0, 5);
    chk(0, 4'b0000, 1, 1, 4'b0000, 2'd0, 0, 5);
    chk(0, 4'b1000, 0, 0, 4'b1000, 2'd3, 0, 5);

    // t2: 3-flit packet on input 0, requester set changes mid-packet
    do_reset();
    chk(0, 4'b0101, 1, 0, 4'b0001, 2'd0, 0, 2);
    chk(0, 4'b0100, 1, 0, 4'b0001, 2'd0, 1, 2);
    chk(0, 4'b0100, 1, 1, 4'b0001, 2'd0, 1, 2);
    chk(0, 4'b0100, 0, 0, 4'b0100, 2'd2, 0, 2);

    // t4: lock on input 2, reset coincident with an update abandons it
    do_reset();
    chk(0, 4'b1111, 1, 1, 4'b0001, 2'd0, 0, 4);
    chk(0, 4'b1111, 1, 1, 4'b0010, 2'd1, 0, 4);
    chk(0, 4'b1111, 1, 0, 4'b0100, 2'd2, 0, 4);
    chk(0, 4'b1111, 1, 0, 4'b0100, 2'd2, 1, 4);
    step(1'b1, 0, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 4);
    chk(0, 4'b1111, 0, 0, 4'b0001, 2'd0, 0, 4);
    chk(0, 4'b1111, 1, 1, 4'b0001, 2'd0, 0, 4);
    chk(0, 4'b1111, 0, 0, 4'b0010, 2'd1, 0, 4);

    // t3: quantum of 2 packets per winner
    do_reset();
    chk(1, 4'b1111, 1, 1, 4'b0001, 2'd0, 0, 3);
    chk(1, 4'b1111, 1, 1, 4'b0001, 2'd0, 0, 3);
    chk(1, 4'b1111, 1, 1, 4'b0010, 2'd1, 0, 3);
    chk(1, 4'b1111, 1, 1, 4'b0010, 2'd1, 0, 3);
    chk(1, 4'b1111, 1, 1, 4'b0100, 2'd2, 0, 3);
    chk(1, 4'b1111, 1, 1, 4'b0100, 2'd2, 0, 3);
    chk(1, 4'b1111, 1, 1, 4'b1000, 2'd3, 0, 3);
    chk(1, 4'b1111, 1, 1, 4'b1000, 2'd3, 0, 3);
    chk(1, 4'b1111, 1, 1, 4'b0001, 2'd0, 0, 3);

    // t4b: packet counter cleared by reset mid-quantum
    do_reset();
    chk(1, 4'b1111, 1, 1, 4'b0001, 2'd0, 0, 41);
    do_reset();
    chk(1, 4'b1111, 1, 1, 4'b0001, 2'd0, 0, 41);
    chk(1, 4'b1111, 1, 1, 4'b0001, 2'd0, 0, 41);
    chk(1, 4'b1111, 0, 0, 4'b0010, 2'd1, 0, 41);

    // t6: LOCK_EN=0, N=3, non-tail updates still rotate
    do_reset();
    chk(2, 4'b0111, 1, 0, 4'b0001, 2'd0, 0, 6);
    chk(2, 4'b0111, 1, 0, 4'b0010, 2'd1, 0, 6);
    chk(2, 4'b0111, 1, 0, 4'b0100, 2'd2, 0, 6);
    chk(2, 4'b0111, 1, 0, 4'b0001, 2'd0, 0, 6);

    // t7: single requester, lock survives request drop
    do_reset();
    chk(3, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, 7);
    chk(3, 4'b0001, 1, 0, 4'b0001, 2'd0, 0, 7);
    chk(3, 4'b0000, 1, 0, 4'b0001, 2'd0, 1, 7);
    chk(3, 4'b0000, 1, 1, 4'b0001, 2'd0, 1, 7);
    chk(3, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, 7);
    chk(3, 4'b0001, 0, 0, 4'b0001, 2'd0, 0, 7);

    step(1'b0, -1, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 2'd0, 1'b0, 0);
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
